// File: rtl/edge_mem_sched_pkg.sv
// edge_mem_sched shared types and geometry helpers.
// Row and frame sizes are derived from the pixel geometry.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } sched_state_t;

  typedef logic [31:0] word_t;

  function automatic int rw_of(int width);
    return width / 4;
  endfunction

  function automatic int words_of(int width, int height);
    return (width / 4) * height;
  endfunction

endpackage

// File: rtl/edge_mem_sched_if.sv
// Accelerator and frame-memory bus of edge_mem_sched.
// master = scheduler side, slave = accelerator/memory side.
interface edge_mem_sched_if
  import edge_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic              acc_start;
  logic              acc_finish;
  logic              acc_en;
  logic              acc_we;
  word_t             acc_dataW;
  logic              row_cached;
  word_t             acc_dataRa;
  word_t             acc_dataRb;
  word_t             acc_dataRc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  word_t             mem_dataW;
  word_t             mem_dataR;

  modport master (
    output acc_start, row_cached,
    output acc_dataRa, acc_dataRb,
    output acc_dataRc,
    output mem_addr, mem_en, mem_we,
    output mem_dataW,
    input  acc_finish, acc_en, acc_we,
    input  acc_dataW, mem_dataR
  );

  modport slave (
    input  acc_start, row_cached,
    input  acc_dataRa, acc_dataRb,
    input  acc_dataRc,
    input  mem_addr, mem_en, mem_we,
    input  mem_dataW,
    output acc_finish, acc_en, acc_we,
    output acc_dataW, mem_dataR
  );

endinterface

// File: rtl/edge_mem_sched_row_fifo.sv
// One-row delay line: output is the word pushed DEPTH pushes ago.
// Reads 0 until DEPTH words have been pushed; clr_i empties it.
module row_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 88
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  push_i,
  input  word_t din_i,
  output word_t dout_o
);

  word_t sr_q [DEPTH];

  assign dout_o = sr_q[DEPTH-1];

  // shift one word per push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else if (push_i) begin
      for (int i = DEPTH - 1; i > 0; i--)
        sr_q[i] <= sr_q[i-1];
      sr_q[0] <= din_i;
    end
  end

endmodule

// File: rtl/edge_mem_sched.sv
// Frame-memory scheduler and three-row cache for the edge accelerator.
// Optional cycle counter: define EDGE_SCHED_STATS_EN.
module edge_mem_sched
  import edge_pkg::*;
#(
  parameter int WIDTH    = 352,
  parameter int HEIGHT   = 288,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25344,
  parameter int WR_SKIP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        done,
  output logic [31:0] cycles,
  edge_mem_sched_if.master bus
);

  localparam int RW    = rw_of(WIDTH);
  localparam int WORDS = words_of(WIDTH, HEIGHT);
  localparam int PW    = $clog2(WORDS + 1);
  localparam int SW    = $clog2(WR_SKIP + 2);

  sched_state_t  state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] land_q;
  logic [SW-1:0] skip_q;
  logic          pend_q;
  logic          zero_q;
  logic          done_q;
  logic          start_q;
  logic          cached_q;
  word_t         rc_q, rb_q, ra_q;
  word_t         f1_out, f2_out, push_w;
  logic          rd_go, rd_zero;
  logic          wr_go, skip_go, clr;

  assign clr    = (state_q == IDLE) && go;
  assign push_w = zero_q ? '0 : bus.mem_dataR;

  // memory port arbitration between self-prefetch and accelerator slots
  always_comb begin
    rd_go   = 1'b0;
    rd_zero = 1'b0;
    wr_go   = 1'b0;
    skip_go = 1'b0;
    if (state_q == PRIME && rd_ptr_q < PW'(RW))
      rd_go = 1'b1;
    if (state_q == RUN && bus.acc_en) begin
      if (bus.acc_we) begin
        if (skip_q < SW'(WR_SKIP))
          skip_go = 1'b1;
        else if (wr_ptr_q < PW'(WORDS))
          wr_go = 1'b1;
      end else if (rd_ptr_q < PW'(WORDS)) begin
        rd_go = 1'b1;
      end else begin
        rd_zero = 1'b1;
      end
    end
  end

  assign bus.mem_en    = rd_go | wr_go;
  assign bus.mem_we    = wr_go;
  assign bus.mem_dataW = wr_go ? bus.acc_dataW : '0;
  assign bus.mem_addr  =
    wr_go ? ADDR_W'(DST_BASE) + ADDR_W'(wr_ptr_q) :
    rd_go ? ADDR_W'(SRC_BASE) + ADDR_W'(rd_ptr_q) :
            '0;

  assign done           = done_q;
  assign bus.acc_start  = start_q;
  assign bus.row_cached = cached_q;
  assign bus.acc_dataRa = ra_q;
  assign bus.acc_dataRb = rb_q;
  assign bus.acc_dataRc = rc_q;

  // frame sequencing, pointers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      land_q   <= '0;
      skip_q   <= '0;
      pend_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      cached_q <= 1'b0;
    end else begin
      pend_q <= rd_go | rd_zero;
      zero_q <= rd_zero;
      if (rd_go)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_go)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (skip_go) skip_q   <= skip_q + 1'b1;
      unique case (state_q)
        IDLE: if (go) begin
          state_q  <= PRIME;
          start_q  <= 1'b1;
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          land_q   <= '0;
          skip_q   <= '0;
        end
        PRIME: if (pend_q) begin
          land_q <= land_q + 1'b1;
          if (land_q == PW'(RW - 1)) begin
            cached_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: if (bus.acc_finish) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          start_q <= 1'b0;
        end
        DONE: if (!go) begin
          state_q  <= IDLE;
          done_q   <= 1'b0;
          cached_q <= 1'b0;
        end
      endcase
    end
  end

  // row pipeline: returned word to Rc, one and two rows back to Rb/Ra
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q <= '0;
      rb_q <= '0;
      ra_q <= '0;
    end else if (clr) begin
      rc_q <= '0;
      rb_q <= '0;
      ra_q <= '0;
    end else if (pend_q) begin
      rc_q <= push_w;
      rb_q <= f1_out;
      ra_q <= f2_out;
    end
  end

  row_fifo #(.DEPTH(RW)) u_fifo1 (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .push_i (pend_q),
    .din_i  (push_w),
    .dout_o (f1_out)
  );

  row_fifo #(.DEPTH(RW)) u_fifo2 (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .push_i (pend_q),
    .din_i  (f1_out),
    .dout_o (f2_out)
  );

`ifdef EDGE_SCHED_STATS_EN
  logic [31:0] cyc_q;

  // count go cycle through finish cycle, hold in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cyc_q <= '0;
    else if (clr)
      cyc_q <= 32'd1;
    else if (state_q == PRIME || state_q == RUN)
      cyc_q <= cyc_q + 32'd1;
  end

  assign cycles = cyc_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_edge_mem_sched.sv
// Scoreboard bench for edge_mem_sched (8x4 frame, RW=2, WORDS=8).
// Expected traffic is queued by stimulus and checked by a monitor.
module tb_edge_mem_sched;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        done;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int g, f, n;

  logic [31:0] mem [0:15];
  wr_t         wq [$];
  logic [15:0] rq [$];
  row_t        rowq [$];

  // hand-computed row outputs for pushes k=2..9
  logic [31:0] exp_c [2:9] = '{32'h13, 32'h14, 32'h15,
    32'h16, 32'h17, 32'h18, 32'h0, 32'h0};
  logic [31:0] exp_b [2:9] = '{32'h11, 32'h12, 32'h13,
    32'h14, 32'h15, 32'h16, 32'h17, 32'h18};
  logic [31:0] exp_a [2:9] = '{32'h0, 32'h0, 32'h11,
    32'h12, 32'h13, 32'h14, 32'h15, 32'h16};

  edge_mem_sched_if #(.ADDR_W(16)) bus ();

  edge_mem_sched #(
    .WIDTH(8), .HEIGHT(4), .ADDR_W(16),
    .SRC_BASE(0), .DST_BASE(8), .WR_SKIP(1)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .done(done), .cycles(cycles), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr[3:0]] <= bus.mem_dataW;
      else
        bus.mem_dataR <= mem[bus.mem_addr[3:0]];
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // monitor: pop expectations as the DUT presents traffic
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en && bus.mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", bus.mem_addr, 32'hFFFF);
        end else begin
          chk("wr_addr", bus.mem_addr, wq[0].addr);
          chk("wr_data", bus.mem_dataW, wq[0].data);
          void'(wq.pop_front());
        end
      end
      if (bus.mem_en && !bus.mem_we) begin
        if (rq.size() == 0) begin
          chk("unexpected_read", bus.mem_addr, 32'hFFFF);
        end else begin
          chk("rd_addr", bus.mem_addr, rq[0]);
          void'(rq.pop_front());
        end
      end
      if (rowq.size() > 0 && rowq[0].due <= cyc) begin
        chk("row_c", bus.acc_dataRc, rowq[0].c);
        chk("row_b", bus.acc_dataRb, rowq[0].b);
        chk("row_a", bus.acc_dataRa, rowq[0].a);
        void'(rowq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(int k);
    step();
    bus.acc_en = 1'b1;
    bus.acc_we = 1'b0;
    if (k < 8)
      rq.push_back(16'(k));
    rowq.push_back('{cyc + 2, exp_a[k], exp_b[k], exp_c[k]});
    if (k >= 8) begin
      #1;
      chk("zero_rd_en", {31'b0, bus.mem_en}, 32'd0);
    end
  endtask

  task automatic wr(int i);
    logic [31:0] d;
    d = 32'hA000_0000 | 32'(i);
    step();
    bus.acc_en    = 1'b1;
    bus.acc_we    = 1'b1;
    bus.acc_dataW = d;
    if (i >= 1 && i <= 8) begin
      wq.push_back('{16'(8 + i - 1), d});
    end else begin
      #1;
      chk("drop_wr_en", {31'b0, bus.mem_en}, 32'd0);
    end
  endtask

  task automatic wait_cached(string name);
    n = 0;
    while (!bus.row_cached && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, bus.row_cached}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_cyc;
    for (int i = 0; i < 16; i++)
      mem[i] = (i < 8) ? 32'h11 + 32'(i) : 32'h0;
    rst = 1'b1;
    go  = 1'b0;
    bus.acc_finish = 1'b0;
    bus.acc_en     = 1'b0;
    bus.acc_we     = 1'b0;
    bus.acc_dataW  = '0;
    bus.mem_dataR  = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_start", {31'b0, bus.acc_start}, 32'd0);
    chk("rst_cached", {31'b0, bus.row_cached}, 32'd0);
    chk("rst_ra", bus.acc_dataRa, 32'd0);
    chk("rst_cycles", cycles, 32'd0);

    step();
    go = 1'b1;
    g = cyc;
    rq.push_back(16'd0);
    rq.push_back(16'd1);
    wait_cached("prime_cached");
    chk("prime_latency", 32'(cyc - g), 32'd4);
    chk("run_start", {31'b0, bus.acc_start}, 32'd1);

    for (int k = 2; k < 6; k++) rd(k);
    for (int i = 0; i < 5; i++) wr(i);
    rd(6);
    rd(7);
    for (int i = 5; i < 10; i++) wr(i);
    rd(8);
    step();
    bus.acc_en = 1'b0;
    rd(9);
    step();
    bus.acc_en = 1'b0;
    repeat (3) step();

    bus.acc_finish = 1'b1;
    f = cyc;
    step();
    bus.acc_finish = 1'b0;
    @(negedge clk);
    chk("fin_done", {31'b0, done}, 32'd1);
    chk("fin_start", {31'b0, bus.acc_start}, 32'd0);
`ifdef EDGE_SCHED_STATS_EN
    exp_cyc = 32'(f - g + 1);
`else
    exp_cyc = 32'd0;
`endif
    chk("cycles", cycles, exp_cyc);
    repeat (5) step();
    @(negedge clk);
    chk("done_held", {31'b0, done}, 32'd1);
    chk("cycles_held", cycles, exp_cyc);
    step();
    go = 1'b0;
    step();
    @(negedge clk);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_cached", {31'b0, bus.row_cached}, 32'd0);

    for (int i = 0; i < 8; i++)
      chk("dst_mem", mem[8 + i], 32'hA000_0000 | 32'(i + 1));

    step();
    go = 1'b1;
    rq.push_back(16'd0);
    rq.push_back(16'd1);
    wait_cached("f2_cached");
    step();
    bus.acc_en    = 1'b1;
    bus.acc_we    = 1'b1;
    bus.acc_dataW = 32'hB0;
    step();
    bus.acc_dataW = 32'hB1;
    #1;
    chk("pre_rst_we", {31'b0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    go  = 1'b0;
    #1;
    chk("mid_rst_en", {31'b0, bus.mem_en}, 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_start", {31'b0, bus.acc_start}, 32'd0);
    chk("mid_rst_cached", {31'b0, bus.row_cached}, 32'd0);
    chk("mid_rst_rc", bus.acc_dataRc, 32'd0);
    chk("mid_rst_rb", bus.acc_dataRb, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_we0", {31'b0, bus.mem_we}, 32'd0);
    step();
    @(negedge clk);
    chk("post_rst_we1", {31'b0, bus.mem_we}, 32'd0);
    bus.acc_en = 1'b0;
    repeat (3) step();

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("rowq_empty", 32'(rowq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
